// File: rtl/spi_reg_ctrl.sv
// Byte-level SPI command sequencer: parses command/data bytes into register bus
// read/write requests and loads status or read data back into the SPI slave.
// Optional SPI_REG_CTRL_AUTOINC_EN enables address auto-increment after each data byte.
module spi_reg_ctrl #(
    parameter logic [7:0] STATUS_BYTE = 8'hA5,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    input  logic       i_ss_n,
    output logic [6:0] o_reg_addr,
    output logic       o_reg_wr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_rd,
    input  logic [7:0] i_reg_rdata,
    input  logic       i_reg_ack,
    output logic       o_busy,
    output logic       o_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_WAIT = 3'd1,
        S_WR_REQ  = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_LOAD = 3'd4,
        S_RD_WAIT = 3'd5
    } state_t;

    localparam logic [7:0] LP_TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_ss_sync;
    logic       r_ss_q;
    logic       r_end_pend;
    logic       r_got_data;
    logic       r_status_pend;
    logic       r_out_en;
    logic [6:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic [7:0] r_cnt;

    logic w_ss_rise;
    logic w_req;
    logic w_timeout;
    logic w_done;
    logic w_status_fire;
    logic w_addr_adv;

    assign w_ss_rise     = r_ss_sync[1] & ~r_ss_q;
    assign w_req         = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
    assign w_timeout     = w_req && (r_cnt == LP_TMO_LAST);
    assign w_done        = w_req && (i_reg_ack || w_timeout);
    // r_out_en keeps the status load out of the reset cycle itself
    assign w_status_fire = (r_state == S_IDLE) && r_status_pend && r_out_en;

`ifdef SPI_REG_CTRL_AUTOINC_EN
    assign w_addr_adv = ((r_state == S_WR_REQ) && w_done) ||
                        ((r_state == S_RD_WAIT) && i_rx_valid && !r_end_pend);
`else
    assign w_addr_adv = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_rx_valid) begin
                    w_next = i_rx_data[7] ? S_RD_REQ : S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (r_end_pend) begin
                    w_next = S_IDLE;
                end else if (i_rx_valid) begin
                    w_next = S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (w_done) begin
                    w_next = r_end_pend ? S_IDLE : S_WR_WAIT;
                end
            end
            S_RD_REQ: begin
                if (w_done) begin
                    w_next = r_end_pend ? S_IDLE : S_RD_LOAD;
                end
            end
            S_RD_LOAD: begin
                w_next = r_end_pend ? S_IDLE : S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (r_end_pend) begin
                    w_next = S_IDLE;
                end else if (i_rx_valid) begin
                    w_next = S_RD_REQ;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_tx_valid  = (r_state == S_RD_LOAD) || w_status_fire;
        o_tx_data   = 8'h00;
        if (r_state == S_RD_LOAD) begin
            o_tx_data = r_rdata;
        end else if (w_status_fire) begin
            o_tx_data = STATUS_BYTE;
        end
        o_reg_wr    = (r_state == S_WR_REQ);
        o_reg_rd    = (r_state == S_RD_REQ);
        o_reg_addr  = r_addr;
        o_reg_wdata = r_wdata;
        o_busy      = (r_state != S_IDLE);
        o_err       = (w_req && i_rx_valid) ||
                      (w_timeout && !i_reg_ack) ||
                      ((r_state == S_WR_WAIT) && r_end_pend && !r_got_data);
    end

    // ss_n idles high, so the synchronizer resets high to avoid a false frame end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ss_sync <= 2'b11;
            r_ss_q    <= 1'b1;
        end else begin
            r_ss_sync <= {r_ss_sync[0], i_ss_n};
            r_ss_q    <= r_ss_sync[1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_end_pend    <= 1'b0;
            r_got_data    <= 1'b0;
            r_status_pend <= 1'b1;
            r_out_en      <= 1'b0;
            r_cnt         <= 8'h00;
        end else begin
            r_out_en <= 1'b1;
            if (w_ss_rise) begin
                r_end_pend <= 1'b1;
            end else if (r_state == S_IDLE) begin
                r_end_pend <= 1'b0;
            end
            if (r_state == S_IDLE) begin
                r_got_data <= 1'b0;
            end else if ((r_state == S_WR_WAIT) && i_rx_valid && !r_end_pend) begin
                r_got_data <= 1'b1;
            end
            if ((r_state != S_IDLE) && (w_next == S_IDLE)) begin
                r_status_pend <= 1'b1;
            end else if (w_status_fire) begin
                r_status_pend <= 1'b0;
            end
            r_cnt <= (w_req && !w_done) ? r_cnt + 8'd1 : 8'h00;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr  <= 7'h00;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
        end else begin
            if ((r_state == S_IDLE) && i_rx_valid) begin
                r_addr <= i_rx_data[6:0];
            end else if (w_addr_adv) begin
                r_addr <= r_addr + 7'd1;
            end
            if ((r_state == S_WR_WAIT) && i_rx_valid && !r_end_pend) begin
                r_wdata <= i_rx_data;
            end
            if ((r_state == S_RD_REQ) && i_reg_ack) begin
                r_rdata <= i_reg_rdata;
            end else if (w_timeout) begin
                r_rdata <= 8'hFF;
            end
        end
    end

endmodule
